seqcordic_mixer_ctrl: RTL and testbench

Sequencer that sits directly upstream and downstream of the DPLL's sequential 16-bit CORDIC rotator. It accepts complex samples on a valid/ready stream and attaches a phase from an internal NCO accumulator. It issues one rotation request to the rotator, waits for the result, removes the CORDIC gain (~1.1644) and presents the mixed sample on a valid/ready output stream. Processing is one sample at a time; one sample occupies the block for roughly 25 cycles.

---
 rtl/seqcordic_mixer_ctrl.sv | 151 +++++++++++++++
 tb/tb_seqcordic_mixer_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seqcordic_mixer_ctrl.sv
// Sample sequencer around the DPLL's sequential CORDIC rotator: attaches an NCO phase,
// issues one rotation, waits for the result, removes the CORDIC gain and presents it downstream.
module seqcordic_mixer_ctrl #(
  parameter int          IW      = 16,
  parameter int          OW      = 16,
  parameter int          PW      = 32,
  parameter logic [15:0] GAIN    = 16'hdbd9,
  parameter int          TIMEOUT = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  // Streams use strict valid/ready: a beat transfers on a rising edge where valid and
  // ready are both high; the source holds valid and data stable until that edge.
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic signed [IW-1:0] s_xval,
  input  logic signed [IW-1:0] s_yval,
  input  logic [PW-1:0]        i_phase_step,
  input  logic                 i_phase_load,
  input  logic [PW-1:0]        i_phase_init,
  output logic                 c_stb,
  output logic [IW-1:0]        c_xval,
  output logic [IW-1:0]        c_yval,
  output logic [PW-1:0]        c_phase,
  input  logic                 c_busy,
  input  logic                 c_done,
  input  logic signed [OW-1:0] c_xres,
  input  logic signed [OW-1:0] c_yres,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [OW-1:0]        m_xval,
  output logic [OW-1:0]        m_yval,
  output logic [PW-1:0]        m_phase,
  output logic                 o_err
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SCALE = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam int XW = OW + 17;
  localparam logic signed [XW-1:0] C_RND  = XW'(32768);
  localparam logic signed [XW-1:0] C_GAIN = {{(OW + 1){1'b0}}, GAIN};

  state_t              r_state;
  state_t              w_next;
  logic [PW-1:0]       r_acc;
  logic [CW-1:0]       r_cnt;
  logic [IW-1:0]       r_cx, r_cy;
  logic [PW-1:0]       r_cphase;
  logic signed [OW-1:0] r_xres, r_yres;
  logic [OW-1:0]       r_mx, r_my;
  logic [PW-1:0]       r_mphase;
  logic                r_err;
  logic                w_accept;
  logic                w_timeout;
  logic signed [XW-1:0] w_rnd_x, w_rnd_y;
  logic                w_unused;

  assign w_accept  = (r_state == ST_IDLE) && s_valid;
  assign w_timeout = (r_state == ST_WAIT) && !c_done && (r_cnt == TO_LAST);

  // Sign-extended multiply by the Q0.16 gain, then +0.5 LSB so the floor shift rounds half up.
  assign w_rnd_x = {{17{r_xres[OW-1]}}, r_xres} * C_GAIN + C_RND;
  assign w_rnd_y = {{17{r_yres[OW-1]}}, r_yres} * C_GAIN + C_RND;
  assign w_unused = ^{w_rnd_x[15:0], w_rnd_x[XW-1], w_rnd_y[15:0], w_rnd_y[XW-1]};

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (s_valid) w_next = ST_ISSUE;
      ST_ISSUE: if (!c_busy) w_next = ST_WAIT;
      ST_WAIT: begin
        if (c_done)         w_next = ST_SCALE;
        else if (w_timeout) w_next = ST_IDLE;
      end
      ST_SCALE: w_next = ST_HOLD;
      ST_HOLD:  if (m_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    s_ready = 1'b0;
    c_stb   = 1'b0;
    m_valid = 1'b0;
    case (r_state)
      ST_IDLE:  s_ready = 1'b1;
      ST_ISSUE: c_stb   = !c_busy;
      ST_HOLD:  m_valid = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_cx     <= '0;
      r_cy     <= '0;
      r_cphase <= '0;
      r_xres   <= '0;
      r_yres   <= '0;
      r_mx     <= '0;
      r_my     <= '0;
      r_mphase <= '0;
      r_err    <= 1'b0;
    end else begin
      // The sample accepted alongside a load still takes the pre-load accumulator.
      if (i_phase_load)  r_acc <= i_phase_init;
      else if (w_accept) r_acc <= r_acc + i_phase_step;
      if (w_accept) begin
        r_cx     <= s_xval;
        r_cy     <= s_yval;
        r_cphase <= r_acc;
      end
      if (r_state == ST_ISSUE)     r_cnt <= '0;
      else if (r_state == ST_WAIT) r_cnt <= r_cnt + 1'b1;
      if ((r_state == ST_WAIT) && c_done) begin
        r_xres <= c_xres;
        r_yres <= c_yres;
      end
      if (r_state == ST_SCALE) begin
        r_mx     <= w_rnd_x[OW+15:16];
        r_my     <= w_rnd_y[OW+15:16];
        r_mphase <= r_cphase;
      end
      if (w_timeout) r_err <= 1'b1;
    end
  end

  assign c_xval  = r_cx;
  assign c_yval  = r_cy;
  assign c_phase = r_cphase;
  assign m_xval  = r_mx;
  assign m_yval  = r_my;
  assign m_phase = r_mphase;
  assign o_err   = r_err;

endmodule

// File: tb/tb_seqcordic_mixer_ctrl.sv
// Bench for seqcordic_mixer_ctrl: table vectors, hand-written corner sequences and
// randomized samples checked against a phase/gain reference model.
module tb_seqcordic_mixer_ctrl;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        s_valid, s_ready;
  logic [15:0] s_xval, s_yval;
  logic [31:0] i_phase_step, i_phase_init;
  logic        i_phase_load;
  logic        c_stb, c_busy, c_done;
  logic [15:0] c_xval, c_yval, c_xres, c_yres;
  logic [31:0] c_phase;
  logic        m_valid, m_ready;
  logic [15:0] m_xval, m_yval;
  logic [31:0] m_phase;
  logic        o_err;

  seqcordic_mixer_ctrl dut (
    .i_clk(clk), .i_reset(i_reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_xval(s_xval), .s_yval(s_yval),
    .i_phase_step(i_phase_step), .i_phase_load(i_phase_load), .i_phase_init(i_phase_init),
    .c_stb(c_stb), .c_xval(c_xval), .c_yval(c_yval), .c_phase(c_phase),
    .c_busy(c_busy), .c_done(c_done), .c_xres(c_xres), .c_yres(c_yres),
    .m_valid(m_valid), .m_ready(m_ready), .m_xval(m_xval), .m_yval(m_yval),
    .m_phase(m_phase), .o_err(o_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];
  longint model_acc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_scale(input logic [15:0] r);
    longint p;
    p = longint'($signed(r)) * 56281 + 32768;
    p = p >>> 16;
    return p[15:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    i_reset = 1'b0;
    model_acc = 0;
  endtask

  task automatic do_load(input logic [31:0] init);
    @(negedge clk);
    i_phase_load = 1'b1;
    i_phase_init = init;
    @(negedge clk);
    i_phase_load = 1'b0;
    model_acc = longint'(init);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (!s_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("s_ready_before_accept", 64'(s_ready), 64'd1);
  endtask

  task automatic run_sample(input logic [15:0] x, input logic [15:0] y,
                            input logic [15:0] xr, input logic [15:0] yr,
                            input logic [31:0] step, input int busy_n,
                            input int done_dly, input int hold_n,
                            input logic load, input logic [31:0] init,
                            input logic [15:0] emx, input logic [15:0] emy,
                            output logic [31:0] obs_phase);
    logic [31:0] ph;
    logic [63:0] e;
    wait_idle();
    ph = model_acc[31:0];
    exp_q.push_back({emx, emy, ph});
    s_valid = 1'b1; s_xval = x; s_yval = y;
    i_phase_step = step; i_phase_load = load; i_phase_init = init;
    c_busy = (busy_n > 0);
    model_acc = load ? longint'(init) : ((model_acc + longint'(step)) & 64'hffff_ffff);
    @(negedge clk);
    s_valid = 1'b0; i_phase_load = 1'b0;
    obs_phase = c_phase;
    check("operands_latched", {c_xval, c_yval, c_phase}, {x, y, ph});
    for (int i = 0; i < busy_n; i++) begin
      check("stb_while_busy", 64'(c_stb), 64'd0);
      @(negedge clk);
    end
    c_busy = 1'b0;
    #1;
    check("stb_pulse", 64'(c_stb), 64'd1);
    @(negedge clk);
    check("stb_single", 64'(c_stb), 64'd0);
    for (int i = 0; i < done_dly; i++) begin
      check("operands_stable", {c_xval, c_yval, c_phase}, {x, y, ph});
      @(negedge clk);
    end
    c_done = 1'b1; c_xres = xr; c_yres = yr;
    @(negedge clk);
    c_done = 1'b0; c_xres = 16'($urandom); c_yres = 16'($urandom);
    check("m_valid_scale", 64'(m_valid), 64'd0);
    @(negedge clk);
    e = exp_q.pop_front();
    check("m_valid_hold", 64'(m_valid), 64'd1);
    check("m_data", {m_xval, m_yval, m_phase}, e);
    for (int i = 0; i < hold_n; i++) begin
      c_done = 1'($urandom);
      @(negedge clk);
      check("hold_stable", {m_valid, s_ready, m_xval, m_yval, m_phase}, {2'b10, e});
    end
    c_done = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    check("after_handshake", {m_valid, s_ready}, 2'b01);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [15:0] x, y, xr, yr;
    logic [15:0] emx, emy;
  } vec_t;

  vec_t vt[6];
  logic [31:0] phase_exp[5];
  logic [31:0] obs;

  initial begin
    vt[0] = '{16'd16384, 16'd0, 16'd19078, 16'd0, 16'd16384, 16'd0};
    vt[1] = '{16'd100, 16'd200, -16'sd19078, 16'd1, -16'sd16384, 16'd1};
    vt[2] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    vt[3] = '{16'd5, 16'd6, 16'd1, -16'sd1, 16'd1, -16'sd1};
    vt[4] = '{16'd7, 16'd8, 16'd32767, -16'sd32768, 16'd28140, -16'sd28140};
    vt[5] = '{16'hffff, 16'h8000, -16'sd32768, 16'd32767, -16'sd28140, 16'd28140};
    phase_exp[0] = 32'h0000_0000; phase_exp[1] = 32'h4000_0000;
    phase_exp[2] = 32'h8000_0000; phase_exp[3] = 32'hC000_0000;
    phase_exp[4] = 32'h0000_0000;

    i_reset = 1'b1; s_valid = 1'b0; s_xval = '0; s_yval = '0;
    i_phase_step = '0; i_phase_load = 1'b0; i_phase_init = '0;
    c_busy = 1'b0; c_done = 1'b0; c_xres = '0; c_yres = '0; m_ready = 1'b0;
    do_reset();
    check("reset_state", {s_ready, c_stb, m_valid, o_err, c_xval, c_phase, m_xval, m_phase},
          {4'b1000, 16'd0, 32'd0, 16'd0, 32'd0});

    // table vectors, step 0 from a zero accumulator
    for (int i = 0; i < 6; i++)
      run_sample(vt[i].x, vt[i].y, vt[i].xr, vt[i].yr, 32'd0, i % 2, i, i % 3,
                 1'b0, 32'd0, vt[i].emx, vt[i].emy, obs);

    // quarter-turn stepping with wrap
    do_load(32'd0);
    for (int i = 0; i < 5; i++) begin
      run_sample(16'd1, 16'd2, 16'd0, 16'd0, 32'h4000_0000, 0, 0, 0,
                 1'b0, 32'd0, 16'd0, 16'd0, obs);
      check("phase_sequence", 64'(obs), 64'(phase_exp[i]));
    end
    // load in the accept cycle: sample keeps old acc, next sample sees init
    run_sample(16'd3, 16'd4, 16'd0, 16'd0, 32'h4000_0000, 0, 0, 0,
               1'b1, 32'h1234_5678, 16'd0, 16'd0, obs);
    check("load_accept_old_acc", 64'(obs), 64'h4000_0000);
    run_sample(16'd3, 16'd4, 16'd0, 16'd0, 32'd1, 0, 0, 0,
               1'b0, 32'd0, 16'd0, 16'd0, obs);
    check("load_accept_next", 64'(obs), 64'h1234_5678);

    // long busy and long hold
    run_sample(16'd16384, 16'd0, 16'd19078, 16'd0, 32'd5, 8, 3, 10,
               1'b0, 32'd0, 16'd16384, 16'd0, obs);

    // timeout: no c_done
    begin
      int cnt;
      logic seen_valid;
      wait_idle();
      s_valid = 1'b1; s_xval = 16'd9; s_yval = 16'd9; i_phase_step = 32'd7;
      model_acc = (model_acc + 7) & 64'hffff_ffff;
      @(negedge clk);
      s_valid = 1'b0;
      check("to_stb", 64'(c_stb), 64'd1);
      @(negedge clk);
      check("to_err_clear", 64'(o_err), 64'd0);
      cnt = 0;
      seen_valid = 1'b0;
      while (!s_ready && cnt < 100) begin
        if (m_valid) seen_valid = 1'b1;
        cnt++;
        @(negedge clk);
      end
      check("to_wait_cycles", 64'(cnt), 64'd32);
      check("to_no_valid", 64'(seen_valid), 64'd0);
      check("to_err_set", 64'(o_err), 64'd1);
    end
    run_sample(16'd16384, 16'd0, 16'd19078, 16'd0, 32'd0, 0, 2, 1,
               1'b0, 32'd0, 16'd16384, 16'd0, obs);
    check("err_sticky", 64'(o_err), 64'd1);
    do_reset();
    check("err_cleared", 64'(o_err), 64'd0);

    // reset mid-operation abandons the sample
    @(negedge clk);
    s_valid = 1'b1; s_xval = 16'h1111; i_phase_step = 32'h100;
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    do_reset();
    check("mid_reset", {s_ready, m_valid, c_xval, c_phase}, {2'b10, 16'd0, 32'd0});

    // randomized samples against the model
    for (int i = 0; i < 25; i++) begin
      logic [15:0] rx, ry;
      logic        ld;
      rx = 16'($urandom);
      ry = 16'($urandom);
      ld = ($urandom_range(0, 7) == 0);
      run_sample(16'($urandom), 16'($urandom), rx, ry, $urandom,
                 $urandom_range(0, 3), $urandom_range(0, 20), $urandom_range(0, 3),
                 ld, $urandom, ref_scale(rx), ref_scale(ry), obs);
    end

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
